// File: rtl/z80_mem_cycle.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | z80_mem_cycle : Z80 opcode-fetch / memory bus cycle sequencer, one clk   |
// | per half T-state. Z80_MEM_CYCLE_WAIT_EN enables nwait wait states.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module z80_mem_cycle #(
    parameter int WAIT_LIMIT = 8
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic        m1,
    input  logic        wr,
    input  logic [15:0] addr_in,
    input  logic [7:0]  wdata,
    input  logic [7:0]  ireg,
    input  logic [7:0]  d_in,
    input  logic        nwait,
    output logic [15:0] a,
    output logic [7:0]  d_out,
    output logic        d_oe,
    output logic        nmreq,
    output logic        nrd,
    output logic        nwr,
    output logic        nm1,
    output logic        nrfsh,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        werr
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T1H  = 4'd1,
        S_T1L  = 4'd2,
        S_T2H  = 4'd3,
        S_T2L  = 4'd4,
        S_TWH  = 4'd5,
        S_TWL  = 4'd6,
        S_T3H  = 4'd7,
        S_T3L  = 4'd8,
        S_T4H  = 4'd9,
        S_T4L  = 4'd10
    } state_t;

    state_t      state;
    logic [7:0]  wdata_q;
    logic        m1_q;
    logic        wr_q;
    logic [7:0]  r_reg;
    logic        take;
    logic        go_wait;
    logic        hit_limit;

    // A new cycle may start from IDLE or from the final (done) state of the previous one.
    assign take = start && ((state == S_IDLE) || (state == S_T4L) ||
                            ((state == S_T3L) && !m1_q));

`ifdef Z80_MEM_CYCLE_WAIT_EN
    localparam int CNT_W = $clog2(WAIT_LIMIT + 2);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    logic [CNT_W-1:0] wcnt;

    always_comb begin
        go_wait   = !nwait && (wcnt < LIMIT);
        hit_limit = !nwait && (wcnt >= LIMIT);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wcnt <= '0;
        end else if (take) begin
            wcnt <= '0;
        end else if (((state == S_T2L) || (state == S_TWL)) && go_wait) begin
            wcnt <= wcnt + 1'b1;
        end
    end
`else
    localparam int unused_wait_limit = WAIT_LIMIT;
    logic unused_nwait;
    assign unused_nwait = nwait;
    assign go_wait      = 1'b0;
    assign hit_limit    = 1'b0;
`endif

    // Outputs are assigned on the edge that enters the state they belong to.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state   <= S_IDLE;
            wdata_q <= 8'h00;
            m1_q    <= 1'b0;
            wr_q    <= 1'b0;
            r_reg   <= 8'h00;
            a       <= 16'h0000;
            d_out   <= 8'h00;
            d_oe    <= 1'b0;
            nmreq   <= 1'b1;
            nrd     <= 1'b1;
            nwr     <= 1'b1;
            nm1     <= 1'b1;
            nrfsh   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= 8'h00;
            werr    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                end
                S_T1H: begin
                    state <= S_T1L;
                    nmreq <= 1'b0;
                    if (m1_q || !wr_q) begin
                        nrd <= 1'b0;
                    end else begin
                        d_oe  <= 1'b1;
                        d_out <= wdata_q;
                    end
                end
                S_T1L: begin
                    state <= S_T2H;
                end
                S_T2H: begin
                    state <= S_T2L;
                    if (!m1_q && wr_q) begin
                        nwr <= 1'b0;
                    end
                end
                S_T2L, S_TWL: begin
                    if (go_wait) begin
                        state <= S_TWH;
                    end else begin
                        state <= S_T3H;
                        if (hit_limit) begin
                            werr <= 1'b1;
                        end
                        // Fetch: opcode sampled at the rising edge of T3, refresh begins.
                        if (m1_q) begin
                            rdata <= d_in;
                            nmreq <= 1'b1;
                            nrd   <= 1'b1;
                            nm1   <= 1'b1;
                            nrfsh <= 1'b0;
                            a     <= {ireg, r_reg};
                        end
                    end
                end
                S_TWH: begin
                    state <= S_TWL;
                end
                S_T3H: begin
                    state <= S_T3L;
                    if (m1_q) begin
                        nmreq <= 1'b0;
                    end else begin
                        if (!wr_q) begin
                            rdata <= d_in;
                        end
                        nmreq <= 1'b1;
                        nrd   <= 1'b1;
                        nwr   <= 1'b1;
                        d_oe  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_T3L: begin
                    if (m1_q) begin
                        state <= S_T4H;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_T4H: begin
                    state <= S_T4L;
                    nmreq <= 1'b1;
                    done  <= 1'b1;
                end
                S_T4L: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    nrfsh <= 1'b1;
                    r_reg <= {r_reg[7], r_reg[6:0] + 7'd1};
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (take) begin
                state   <= S_T1H;
                wdata_q <= wdata;
                m1_q    <= m1;
                wr_q    <= wr;
                a       <= addr_in;
                nm1     <= ~m1;
                busy    <= 1'b1;
                werr    <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_z80_mem_cycle.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_z80_mem_cycle : randomized scoreboard bench for z80_mem_cycle         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_z80_mem_cycle;

    localparam int WL = 8;
`ifdef Z80_MEM_CYCLE_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nreset, start, m1, wr, nwait;
    logic [15:0] addr_in;
    logic [7:0]  wdata, ireg, d_in;
    logic [15:0] a;
    logic [7:0]  d_out, rdata;
    logic        d_oe, nmreq, nrd, nwr, nm1, nrfsh, busy, done, werr;

    z80_mem_cycle #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .nreset(nreset), .start(start), .m1(m1), .wr(wr),
        .addr_in(addr_in), .wdata(wdata), .ireg(ireg), .d_in(d_in), .nwait(nwait),
        .a(a), .d_out(d_out), .d_oe(d_oe), .nmreq(nmreq), .nrd(nrd), .nwr(nwr),
        .nm1(nm1), .nrfsh(nrfsh), .busy(busy), .done(done), .rdata(rdata), .werr(werr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          m1;
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  ireg;
        int          L;
        logic [7:0]  exp_r;
        logic [7:0]  exp_rdata;
        bit          exp_werr;
        bit          b2b;
    } txn_t;

    txn_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model_r = 8'h00;
    logic [7:0]  model_rdata = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int waits_of(input int k);
        if (!WAIT_EN) return 0;
        return (k < WL) ? k : WL;
    endfunction

    // Strobe picture {nmreq,nrd,nwr,nm1,nrfsh,d_oe} for half-T index i of an L-long cycle.
    function automatic logic [5:0] exp_vec(input bit mm1, input bit wwr, input int i, input int L);
        bit mreq_lo, rd_lo, wr_lo, m1_lo, rf_lo, oe;
        if (mm1) begin
            m1_lo   = (i <= L - 5);
            mreq_lo = (i >= 1 && i <= L - 5) || (i >= L - 3 && i <= L - 2);
            rd_lo   = (i >= 1 && i <= L - 5);
            rf_lo   = (i >= L - 4);
            wr_lo   = 1'b0;
            oe      = 1'b0;
        end else begin
            mreq_lo = (i >= 1 && i <= L - 2);
            rd_lo   = !wwr && mreq_lo;
            wr_lo   = wwr && (i >= 3) && (i <= L - 2);
            oe      = wwr && mreq_lo;
            m1_lo   = 1'b0;
            rf_lo   = 1'b0;
        end
        return {~mreq_lo, ~rd_lo, ~wr_lo, ~m1_lo, ~rf_lo, oe};
    endfunction

    // ---------------- monitor ----------------
    logic [5:0]  tr_v[$];
    logic [15:0] tr_a[$];
    logic [7:0]  tr_d[$];
    bit          rst_edge = 1'b0;
    bit          exp_busy_next = 1'b0;

    always @(posedge clk) rst_edge = !nreset;

    task automatic finish_txn();
        txn_t t;
        int   n;
        int   m;
        logic [15:0] ea;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done=1 with no cycle outstanding");
        end else begin
            t = sb.pop_front();
            n = tr_v.size();
            check("latency", n, t.L);
            m = (n < t.L) ? n : t.L;
            for (int i = 0; i < m; i++) begin
                check($sformatf("strobes[%0d]", i), tr_v[i], exp_vec(t.m1, t.wr, i, t.L));
                ea = (t.m1 && i >= t.L - 4) ? {t.ireg, t.exp_r} : t.addr;
                check($sformatf("addr[%0d]", i), tr_a[i], ea);
                if (!t.m1 && t.wr && i >= 1 && i <= t.L - 2)
                    check($sformatf("d_out[%0d]", i), tr_d[i], t.wdata);
            end
            check("rdata", rdata, t.exp_rdata);
            check("werr", werr, t.exp_werr);
        end
        tr_v.delete();
        tr_a.delete();
        tr_d.delete();
        exp_busy_next = (sb.size() > 0) && sb[0].b2b;
    endtask

    always @(negedge clk) begin
        if (rst_edge) begin
            tr_v.delete();
            tr_a.delete();
            tr_d.delete();
            exp_busy_next = 1'b0;
            check("reset_state",
                  {nmreq, nrd, nwr, nm1, nrfsh, d_oe, busy, done, werr, a, d_out, rdata},
                  {5'b11111, 1'b0, 3'b000, 16'h0000, 8'h00, 8'h00});
        end else begin
            if (exp_busy_next) begin
                check("back_to_back_busy", busy, 1'b1);
                exp_busy_next = 1'b0;
            end
            if (busy === 1'b1) begin
                tr_v.push_back({nmreq, nrd, nwr, nm1, nrfsh, d_oe});
                tr_a.push_back(a);
                tr_d.push_back(d_out);
            end else begin
                check("idle_outputs", {nmreq, nrd, nwr, nm1, nrfsh, d_oe, done}, 7'b1111100);
            end
            if (done === 1'b1 && busy === 1'b1) finish_txn();
        end
    end

    // ---------------- driver ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after an edge; returns just after the edge that enters the done state.
    task automatic run_txn(input bit mm1, input bit wwr, input logic [15:0] ad, input logic [7:0] wd,
                           input logic [7:0] din, input logic [7:0] ir, input int k,
                           input bit b2b, input bit junk);
        txn_t t;
        int   w;
        w           = waits_of(k);
        t.m1        = mm1;
        t.wr        = wwr;
        t.addr      = ad;
        t.wdata     = wd;
        t.ireg      = ir;
        t.L         = (mm1 ? 8 : 6) + 2 * w;
        t.exp_werr  = WAIT_EN && (k > WL);
        t.exp_r     = model_r;
        t.b2b       = b2b;
        if (mm1) model_r = {model_r[7], model_r[6:0] + 7'd1};
        if (mm1 || !wwr) model_rdata = din;
        t.exp_rdata = model_rdata;
        sb.push_back(t);

        start   = 1'b1;
        m1      = mm1;
        wr      = wwr;
        addr_in = ad;
        wdata   = wd;
        d_in    = din;
        ireg    = ir;
        nwait   = 1'b1;
        @(posedge clk);
        #1;
        for (int e = 1; e <= t.L - 1; e++) begin
            start   = junk && ($urandom_range(3) == 0);
            addr_in = 16'($urandom);
            wdata   = 8'($urandom);
            m1      = 1'($urandom);
            wr      = 1'($urandom);
            nwait   = (e >= 4 && e < 4 + 2 * k) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        nwait = 1'b1;
    endtask

    initial begin
        int  kind, k, gap;
        bit  b2b;
        nreset  = 1'b0;
        start   = 1'b0;
        m1      = 1'b0;
        wr      = 1'b0;
        nwait   = 1'b1;
        addr_in = 16'h0000;
        wdata   = 8'h00;
        ireg    = 8'h00;
        d_in    = 8'h00;
        idle(3);
        nreset = 1'b1;
        idle(2);

        // Reset in T2L of a write aborts it without done or R change.
        start = 1'b1; m1 = 1'b0; wr = 1'b1; addr_in = 16'hC000; wdata = 8'hA5;
        idle(1);
        start = 1'b0;
        idle(3);
        check("abort_nwr_in_t2l", nwr, 1'b0);
        nreset = 1'b0;
        idle(1);
        nreset = 1'b1;
        model_r = 8'h00;
        model_rdata = 8'h00;
        idle(4);

        run_txn(1'b1, 1'b0, 16'h1234, 8'h00, 8'hC3, 8'h3F, 0, 1'b0, 1'b0);
        idle(1);
        run_txn(1'b0, 1'b0, 16'h8000, 8'h00, 8'h5A, 8'h3F, 0, 1'b0, 1'b0);
        idle(1);
        run_txn(1'b0, 1'b1, 16'hC000, 8'hA5, 8'h11, 8'h3F, 0, 1'b0, 1'b0);
        idle(1);
        run_txn(1'b0, 1'b0, 16'h4000, 8'h00, 8'h77, 8'h3F, 2, 1'b0, 1'b0);
        idle(1);
        run_txn(1'b0, 1'b0, 16'h4001, 8'h00, 8'h88, 8'h3F, 20, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 16'h4002, 8'h00, 8'h99, 8'h3F, 0, 1'b1, 1'b0);
        idle(2);

        for (int n = 0; n < 128; n++)
            run_txn(1'b1, 1'b0, 16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    0, (n > 0), 1'b0);
        idle(1);

        b2b = 1'b0;
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(2);
            k    = ($urandom_range(3) == 0) ? $urandom_range(10) : 0;
            run_txn(kind == 0, kind == 2, 16'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), k, b2b, 1'($urandom));
            gap = $urandom_range(2);
            idle(gap);
            b2b = (gap == 0);
        end

        idle(4);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d cycles never completed, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
